instruction_fetch: RTL
======================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, giving the maximum number of FETCH cycles to wait for imem_ack (range 2..255).
REQ-002 The block SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous, active-high reset sampled on the rising clk edge.
REQ-004 The block SHALL have port pc, input, 32, current PC value from the program counter register.
REQ-005 The block SHALL have port next_pc, output, 32, value the program counter loads on the next clk edge.
REQ-006 The block SHALL have port branch_taken, input, 1, redirect request from the execute stage.
REQ-007 The block SHALL have port branch_target, input, 32, redirect address, valid when branch_taken=1.
REQ-008 The block SHALL have port imem_req, output, 1, instruction memory read request.
REQ-009 The block SHALL have port imem_addr, output, 32, read address, valid when imem_req=1.
REQ-010 The block SHALL have port imem_ack, input, 1, read data valid this cycle; ignored when imem_req=0.
REQ-011 The block SHALL have port imem_rdata, input, 32, instruction word, valid when imem_ack=1.
REQ-012 The block SHALL have port instr, output, 32, fetched instruction word for decode.
REQ-013 The block SHALL have port instr_pc, output, 32, address the instr word was fetched from.
REQ-014 The block SHALL have port instr_valid, output, 1, instr/instr_pc hold a valid instruction.
REQ-015 The block SHALL have port stall, input, 1, decode cannot accept; an instruction is consumed in any cycle with instr_valid=1 and stall=0.
REQ-016 The block SHALL have port fetch_error, output, 1, sticky error flag (timeout or misaligned PC).

Function
REQ-017 The block SHALL implement a registered FSM with states IDLE, FETCH, HOLD, ERROR.
REQ-018 IDLE: outputs inactive, next_pc=pc; the block SHALL move to FETCH on the next edge.
REQ-019 FETCH: the block SHALL drive imem_req=1 and imem_addr=pc, and increment an 8-bit wait counter each cycle without ack.
REQ-020 FETCH with imem_ack=1: the block SHALL register instr<=imem_rdata and instr_pc<=pc, drive next_pc=pc+4 (mod 2^32, 0xFFFFFFFC wraps to 0x00000000) that cycle, clear the wait counter and enter HOLD.
REQ-021 FETCH without ack: the block SHALL drive next_pc=pc so the PC holds.
REQ-022 FETCH with the wait counter reaching TIMEOUT-1 and no ack: the block SHALL set fetch_error=1, drop imem_req and enter ERROR.
REQ-023 FETCH with pc[1:0]!=0: the block SHALL NOT assert imem_req, SHALL set fetch_error=1 and enter ERROR that edge.
REQ-024 HOLD: the block SHALL drive instr_valid=1, imem_req=0 and next_pc=pc; it SHALL keep instr/instr_pc stable while stall=1, and on stall=0 SHALL clear instr_valid and enter FETCH.
REQ-025 ERROR: the block SHALL drive imem_req=0, instr_valid=0, next_pc=pc and hold until reset or branch_taken.
REQ-026 branch_taken=1 in any state SHALL have highest priority: next_pc=branch_target that cycle, instr_valid cleared, fetch_error cleared, wait counter cleared, state -> FETCH; a simultaneous imem_ack SHALL be discarded.
REQ-027 Dropping imem_req on a branch abort SHALL be legal; the memory SHALL treat the next request as new.
REQ-028 Throughput SHALL be at most one instruction per two cycles; latency from entering FETCH to instr_valid SHALL be ack-cycle + 1.
REQ-029 next_pc, imem_req and imem_addr SHALL be combinational from state, pc, branch inputs and imem_ack; all other outputs SHALL be registered.

Reset
REQ-030 reset=1 SHALL force state IDLE, instr=0, instr_pc=0, instr_valid=0, fetch_error=0, wait counter=0 on the next edge.
REQ-031 While reset=1, the block SHALL drive next_pc=0 and imem_req=0 regardless of other inputs, including mid-fetch.
REQ-032 Reset SHALL take priority over branch_taken.

Verification
REQ-033 Reset, pc=0, memory acks in 1 cycle returning 0x00500093 -> instr_valid=1, instr=0x00500093, instr_pc=0, next PC=4.
REQ-034 stall=1 for 3 cycles in HOLD -> instr and instr_pc are unchanged, imem_req=0, pc is constant; stall=0 -> FETCH at the same pc.
REQ-035 branch_taken=1 with target 0x100 coincident with imem_ack -> ack data is dropped, next_pc=0x100, and the next fetch is issued at 0x100.
REQ-036 TIMEOUT=16, no ack -> fetch_error=1 after exactly 16 FETCH cycles, the block stays in ERROR, and branch_taken clears the error.
REQ-037 Branch to 0x102 -> no imem_req at 0x102, fetch_error=1 on the next edge.
REQ-038 pc=0xFFFFFFFC acked -> next_pc=0x00000000; reset asserted during FETCH -> imem_req=0 in the same cycle and all outputs are zero after the edge.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - instruction memory read bus between fetch and imem
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-outstanding instruction fetch FSM with timeout and redirect
module instruction_fetch #(
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                pc,
    output logic [31:0]                next_pc,
    input  logic                       branch_taken,
    input  logic [31:0]                branch_target,
    instruction_fetch_if.master        imem,
    output logic [31:0]                instr,
    output logic [31:0]                instr_pc,
    output logic                       instr_valid,
    input  logic                       stall,
    output logic                       fetch_error
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] ERROR = 2'd3;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic       misaligned;

    assign misaligned = |pc[1:0];

    // A redirect drops the request so any ack arriving in the same cycle is discarded.
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc;
        next_pc        = pc;
        if (reset) begin
            next_pc = 32'h0;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end else if (state == FETCH && !misaligned) begin
            imem.imem_req = 1'b1;
            if (imem.imem_ack) begin
                next_pc = pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
            fetch_error <= 1'b0;
        end else if (branch_taken) begin
            state       <= FETCH;
            wait_cnt    <= 8'd0;
            instr_valid <= 1'b0;
            fetch_error <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (misaligned) begin
                        fetch_error <= 1'b1;
                        wait_cnt    <= 8'd0;
                        state       <= ERROR;
                    end else if (imem.imem_ack) begin
                        instr       <= imem.imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        wait_cnt    <= 8'd0;
                        state       <= HOLD;
                    end else if (wait_cnt == LAST_WAIT) begin
                        fetch_error <= 1'b1;
                        wait_cnt    <= 8'd0;
                        state       <= ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                default: state <= ERROR;
            endcase
        end
    end
endmodule
